// File: rtl/sbox_share_arbiter.sv
`timescale 1ns/1ps
// Shared AES S-box: captures the table and serves ke/sb word lookups (SBOX_ARB_ROUND_ROBIN_EN: alternating collision grant).
// Latency: grant is combinational; the substituted word is registered one cycle later.
// Backpressure: a requester holds req/word until it sees gnt; load cycles and the unloaded table stall both.
module sbox_share_arbiter #(
    parameter int WORD_W       = 32,
    parameter int SBOX_ENTRIES = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SBOX_ENTRIES*8-1:0] sbox_in,
    input  logic                      sbox_in_vld,
    output logic                      sbox_available,
    input  logic                      ke_req,
    input  logic [WORD_W-1:0]         ke_word,
    output logic                      ke_gnt,
    output logic [WORD_W-1:0]         ke_rsp,
    output logic                      ke_rsp_vld,
    input  logic                      sb_req,
    input  logic [WORD_W-1:0]         sb_word,
    output logic                      sb_gnt,
    output logic [WORD_W-1:0]         sb_rsp,
    output logic                      sb_rsp_vld,
    output logic                      busy
);
    localparam int NBYTES = WORD_W / 8;

    logic [7:0]        sbox_tbl [SBOX_ENTRIES];
    logic              lookup_ok;
    logic              sb_wins;
    logic [WORD_W-1:0] sel_word;
    logic [WORD_W-1:0] sub_word;

`ifdef SBOX_ARB_ROUND_ROBIN_EN
    // rr_ptr=0 favours ke, 1 favours sb; it flips to the loser after every grant.
    logic rr_ptr;

    assign sb_wins = sb_req && (!ke_req || rr_ptr);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (ke_gnt) begin
            rr_ptr <= 1'b1;
        end else if (sb_gnt) begin
            rr_ptr <= 1'b0;
        end
    end
`else
    assign sb_wins = sb_req && !ke_req;
`endif

    // A load cycle blocks lookups so nobody reads a half-written table.
    assign lookup_ok = sbox_available && !sbox_in_vld;
    assign ke_gnt    = lookup_ok && ke_req && !sb_wins;
    assign sb_gnt    = lookup_ok && sb_wins;
    assign sel_word  = sb_gnt ? sb_word : ke_word;

    always_comb begin
        sub_word = '0;
        for (int i = 0; i < NBYTES; i++) begin
            sub_word[8*i +: 8] = sbox_tbl[sel_word[8*i +: 8]];
        end
    end

    always_ff @(posedge clk) begin
        if (sbox_in_vld && !reset) begin
            for (int k = 0; k < SBOX_ENTRIES; k++) begin
                sbox_tbl[k] <= sbox_in[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sbox_available <= 1'b0;
            ke_rsp_vld     <= 1'b0;
            sb_rsp_vld     <= 1'b0;
            ke_rsp         <= '0;
            sb_rsp         <= '0;
            busy           <= 1'b0;
        end else begin
            if (sbox_in_vld) begin
                sbox_available <= 1'b1;
            end
            ke_rsp_vld <= ke_gnt;
            sb_rsp_vld <= sb_gnt;
            busy       <= ke_gnt || sb_gnt;
            if (ke_gnt) begin
                ke_rsp <= sub_word;
            end
            if (sb_gnt) begin
                sb_rsp <= sub_word;
            end
        end
    end
endmodule

// File: tb/tb_sbox_share_arbiter.sv
`timescale 1ns/1ps
// Bench for sbox_share_arbiter: grant vectors from a table, responses checked by a queue scoreboard.
module tb_sbox_share_arbiter;
    localparam int WORD_W       = 32;
    localparam int SBOX_ENTRIES = 256;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [SBOX_ENTRIES*8-1:0] sbox_in;
    logic                      sbox_in_vld;
    logic                      sbox_available;
    logic                      ke_req, sb_req;
    logic [WORD_W-1:0]         ke_word, sb_word;
    logic                      ke_gnt, sb_gnt;
    logic [WORD_W-1:0]         ke_rsp, sb_rsp;
    logic                      ke_rsp_vld, sb_rsp_vld;
    logic                      busy;

    always #5 clk = ~clk;

    sbox_share_arbiter #(.WORD_W(WORD_W), .SBOX_ENTRIES(SBOX_ENTRIES)) dut (
        .clk(clk), .reset(reset), .sbox_in(sbox_in), .sbox_in_vld(sbox_in_vld),
        .sbox_available(sbox_available),
        .ke_req(ke_req), .ke_word(ke_word), .ke_gnt(ke_gnt), .ke_rsp(ke_rsp), .ke_rsp_vld(ke_rsp_vld),
        .sb_req(sb_req), .sb_word(sb_word), .sb_gnt(sb_gnt), .sb_rsp(sb_rsp), .sb_rsp_vld(sb_rsp_vld),
        .busy(busy)
    );

    typedef struct {
        logic        ke_req;
        logic        sb_req;
        logic [31:0] ke_word;
        logic [31:0] sb_word;
        logic        exp_ke_gnt;
        logic        exp_sb_gnt;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [7:0]                mdl_tbl [256];
    logic [31:0]               ke_q[$];
    logic [31:0]               sb_q[$];
    logic [127:0]              aes_rows [16];
    logic [SBOX_ENTRIES*8-1:0] aes_img, aa_img;
    vec_t                      vecs [8];

    bit          mon_en     = 1'b0;
    bit          prev_rst   = 1'b1;
    bit          exp_ke_vld = 1'b0;
    bit          exp_sb_vld = 1'b0;
    logic [31:0] last_ke    = '0;
    logic [31:0] last_sb    = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sub_model(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = mdl_tbl[w[8*i +: 8]];
        return r;
    endfunction

    task automatic model_load(input logic [SBOX_ENTRIES*8-1:0] img);
        for (int k = 0; k < 256; k++) mdl_tbl[k] = img[8*k +: 8];
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string nm, input logic eke, input logic esb, input logic eav);
        @(negedge clk);
        chk({nm, "_ke_gnt"}, ke_gnt, eke);
        chk({nm, "_sb_gnt"}, sb_gnt, esb);
        chk({nm, "_avail"}, sbox_available, eav);
        adv();
    endtask

    // Scoreboard: a grant not killed by reset pushes the model result; it must appear next cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_rst) begin
                last_ke = '0;
                last_sb = '0;
            end else begin
                if (exp_ke_vld) last_ke = ke_q.pop_front();
                if (exp_sb_vld) last_sb = sb_q.pop_front();
            end
            chk("sb_ke_rsp_vld", ke_rsp_vld, exp_ke_vld);
            chk("sb_sb_rsp_vld", sb_rsp_vld, exp_sb_vld);
            chk("sb_busy", busy, exp_ke_vld || exp_sb_vld);
            chk("sb_ke_rsp", ke_rsp, last_ke);
            chk("sb_sb_rsp", sb_rsp, last_sb);
            chk("sb_gnt_excl", ke_gnt && sb_gnt, 1'b0);
            exp_ke_vld = ke_gnt && !reset;
            exp_sb_vld = sb_gnt && !reset;
            if (exp_ke_vld) ke_q.push_back(sub_model(ke_word));
            if (exp_sb_vld) sb_q.push_back(sub_model(sb_word));
            prev_rst = reset;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aes_rows = '{
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                aes_img[8*(16*r+c) +: 8] = aes_rows[r][127-8*c -: 8];
        aa_img = {SBOX_ENTRIES{8'haa}};

        vecs[0] = '{1'b1, 1'b0, 32'h0a1b2c3d, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h00000000, 32'h12345678, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 32'hffffffff, 32'hffffffff, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'hdeadbeef, 32'h00000000, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h00000000, 32'hcafef00d, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 32'h55555555, 32'h00ff00ff, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 32'h11223344, 32'h99999999, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0};

        reset = 1'b1; sbox_in = '0; sbox_in_vld = 1'b0;
        ke_req = 1'b0; ke_word = '0; sb_req = 1'b0; sb_word = '0;
        adv();
        mon_en = 1'b1;
        adv();
        @(negedge clk);
        chk("rst_avail", sbox_available, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ke_rsp", ke_rsp, 32'h0);
        chk("rst_sb_rsp_vld", sb_rsp_vld, 1'b0);
        adv();
        reset = 1'b0;

        // Request before and across the first load.
        ke_req = 1'b1; ke_word = 32'h00010253;
        cyc("preload0", 1'b0, 1'b0, 1'b0);
        cyc("preload1", 1'b0, 1'b0, 1'b0);
        sbox_in = aes_img; sbox_in_vld = 1'b1; model_load(aes_img);
        cyc("load", 1'b0, 1'b0, 1'b0);
        sbox_in_vld = 1'b0;
        cyc("postload", 1'b1, 1'b0, 1'b1);
        ke_req = 1'b0;
        @(negedge clk);
        chk("t1_ke_rsp", ke_rsp, 32'h637c77ed);
        chk("t1_ke_vld", ke_rsp_vld, 1'b1);
        chk("t1_sb_vld", sb_rsp_vld, 1'b0);
        adv();

        sb_req = 1'b1; sb_word = 32'hffffffff;
        cyc("sb_ff", 1'b0, 1'b1, 1'b1);
        sb_req = 1'b0;
        @(negedge clk);
        chk("t2_sb_rsp", sb_rsp, 32'h16161616);
        chk("t2_sb_vld", sb_rsp_vld, 1'b1);
        adv();
        @(negedge clk);
        chk("t2_sb_pulse", sb_rsp_vld, 1'b0);
        chk("t2_sb_hold", sb_rsp, 32'h16161616);
        adv();

        for (int i = 0; i < 8; i++) begin
            ke_req = vecs[i].ke_req; sb_req = vecs[i].sb_req;
            ke_word = vecs[i].ke_word; sb_word = vecs[i].sb_word;
            cyc($sformatf("vec%0d", i), vecs[i].exp_ke_gnt, vecs[i].exp_sb_gnt, 1'b1);
        end
        ke_req = 1'b0; sb_req = 1'b0;
        adv();

        // Collision run from a fresh reset so any pointer starts at ke.
        reset = 1'b1;
        adv();
        reset = 1'b0;
        sbox_in = aes_img; sbox_in_vld = 1'b1; model_load(aes_img);
        cyc("reload", 1'b0, 1'b0, 1'b0);
        sbox_in_vld = 1'b0;
        ke_req = 1'b1; ke_word = 32'h00000000;
        sb_req = 1'b1; sb_word = 32'h01010101;
        begin
            bit prev_sb = 1'b0;
            for (int i = 0; i < 4; i++) begin
                bit want_sb;
`ifdef SBOX_ARB_ROUND_ROBIN_EN
                want_sb = (i % 2) == 1;
`else
                want_sb = 1'b0;
`endif
                @(negedge clk);
                chk($sformatf("coll%0d_ke_gnt", i), ke_gnt, !want_sb);
                chk($sformatf("coll%0d_sb_gnt", i), sb_gnt, want_sb);
                if (i > 0) begin
                    if (prev_sb) chk($sformatf("coll%0d_sb_rsp", i), sb_rsp, 32'h7c7c7c7c);
                    else         chk($sformatf("coll%0d_ke_rsp", i), ke_rsp, 32'h63636363);
                end
                prev_sb = want_sb;
                adv();
            end
            ke_req = 1'b0; sb_req = 1'b0;
            @(negedge clk);
            if (prev_sb) chk("coll4_sb_rsp", sb_rsp, 32'h7c7c7c7c);
            else         chk("coll4_ke_rsp", ke_rsp, 32'h63636363);
            adv();
        end

        // Load of all-AA table while ke is waiting.
        ke_req = 1'b1; ke_word = 32'h01234567;
        sbox_in = aa_img; sbox_in_vld = 1'b1; model_load(aa_img);
        cyc("aa_load", 1'b0, 1'b0, 1'b1);
        sbox_in_vld = 1'b0;
        cyc("aa_after", 1'b1, 1'b0, 1'b1);
        ke_req = 1'b0;
        @(negedge clk);
        chk("aa_ke_rsp", ke_rsp, 32'haaaaaaaa);
        adv();

        // Reset in the cycle after a grant; later lookups must wait for a reload.
        ke_req = 1'b1; ke_word = 32'h00000000;
        cyc("pre_rst", 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        adv();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ke_vld", ke_rsp_vld, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_avail", sbox_available, 1'b0);
        chk("mid_rst_gnt", ke_gnt, 1'b0);
        adv();
        cyc("post_rst1", 1'b0, 1'b0, 1'b0);
        cyc("post_rst2", 1'b0, 1'b0, 1'b0);

        reset = 1'b1; sbox_in = aes_img; sbox_in_vld = 1'b1;
        adv();
        reset = 1'b0; sbox_in_vld = 1'b0;
        cyc("rst_load_win", 1'b0, 1'b0, 1'b0);

        model_load(aes_img);
        sbox_in_vld = 1'b1; ke_word = 32'h53535353;
        cyc("final_load", 1'b0, 1'b0, 1'b0);
        sbox_in_vld = 1'b0;
        cyc("final_gnt", 1'b1, 1'b0, 1'b1);
        ke_req = 1'b0;
        @(negedge clk);
        chk("final_ke_rsp", ke_rsp, 32'hedededed);
        adv();
        adv();

        chk("ke_q_drained", ke_q.size(), 0);
        chk("sb_q_drained", sb_q.size(), 0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sbox_share_arbiter.md
Name: sbox_share_arbiter

Overview:
- Owns the single S-box lookup resource shared by the key-expansion path and the SubBytes path of the AES-128 core.
- Captures the 256-entry substitution table from the chip-level sbox load interface.
- Arbitrates word-wide (4-byte) lookup requests from the two requesters and returns the registered result with a one-cycle latency.
- Sits between key_expansion, flow_cntr and mix_columns.
- Replaces direct dual-port table access, so only one substitution unit exists.

Parameters:
- WORD_W, 32, lookup word width in bits; must be a multiple of 8.
- SBOX_ENTRIES, 256, number of 8-bit table entries.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sbox_in  input  SBOX_ENTRIES*8  table image; entry k occupies bits [8k+7:8k]
- sbox_in_vld  input  1  load strobe for sbox_in
- sbox_available  output  1  table loaded and usable
- ke_req  input  1  key-expansion lookup request
- ke_word  input  WORD_W  key-expansion word to substitute
- ke_gnt  output  1  key-expansion request accepted this cycle
- ke_rsp  output  WORD_W  key-expansion substituted word
- ke_rsp_vld  output  1  ke_rsp valid (1-cycle pulse)
- sb_req  input  1  SubBytes lookup request
- sb_word  input  WORD_W  SubBytes word to substitute
- sb_gnt  output  1  SubBytes request accepted this cycle
- sb_rsp  output  WORD_W  SubBytes substituted word
- sb_rsp_vld  output  1  sb_rsp valid (1-cycle pulse)
- busy  output  1  a lookup is in flight (granted last cycle, response this cycle)

Behaviour:
- Reset and clock:
  - Single clock domain; clk is the only clock.
  - reset is synchronous and active-high.
  - Reset values: sbox_available=0, ke_rsp_vld=0, sb_rsp_vld=0, ke_rsp=0, sb_rsp=0, busy=0, priority pointer=KE.
  - Table contents are not reset and are don't-care until the first load.
- Table load:
  - On a clk edge with sbox_in_vld=1, capture the full sbox_in into the table.
  - sbox_available=1 from the next cycle; it stays 1 until reset.
  - A new sbox_in_vld overwrites the table; sbox_available stays 1.
- Grants are combinational from the current req inputs and state:
  - No grant while sbox_available=0 or sbox_in_vld=1. A load cycle blocks lookups, so no request ever sees a half-updated table.
  - Otherwise, if exactly one req is high, that requester is granted.
  - If both are high, default fixed priority grants ke (ke_gnt=1, sb_gnt=0).
  - ke_gnt and sb_gnt are never both 1.
- Requester protocol:
  - Assert req with the word stable, and hold both until gnt=1 is seen in the same cycle.
  - May deassert req, or present a new word, on the cycle after gnt.
  - Deasserting req before grant is legal; the request is simply dropped.
- Lookup:
  - The granted word's byte i (bits [8i+7:8i]) is replaced by table[byte i], independently for all WORD_W/8 bytes.
  - Result is registered: grant in cycle N gives rsp and rsp_vld=1 for exactly cycle N+1 on the granted requester's port only.
- Response hold:
  - ke_rsp and sb_rsp hold their last value when not valid.
  - The other port's rsp_vld stays 0.
- Throughput:
  - One grant per cycle, back-to-back allowed.
  - busy=1 in every cycle in which any rsp_vld=1.
- reset mid-operation: in-flight response is discarded (rsp_vld=0 on the cycle after reset), sbox_available=0, and no grants until a new load.
- Simultaneous reset and sbox_in_vld: reset wins; the table is not marked available.

Optional Feature:
- Macro SBOX_ARB_ROUND_ROBIN_EN.
- Defined: on both-request collisions, grant alternates using a 1-bit pointer.
  - Pointer resets to KE.
  - After each grant, the pointer points to the other requester.
  - A collision grants the requester the pointer indicates.
  - Single-request cycles also update the pointer.
- Undefined: fixed priority, ke always wins collisions, and no pointer flop exists.

Test Plan:
- Reset, then load the standard AES S-box; ke_req=1 with ke_word=32'h00010253 before and after load -> no ke_gnt before sbox_available; after load, ke_gnt=1 and next cycle ke_rsp=32'h637c77ed, ke_rsp_vld=1, sb_rsp_vld=0.
- Standard S-box loaded; sb_req=1 with sb_word=32'hffffffff -> sb_gnt same cycle, sb_rsp=32'h16161616 one cycle later, 1-cycle pulse.
- Both requesting for 4 cycles with ke_word=32'h00000000, sb_word=32'h01010101:
  - Without macro: ke granted every cycle, ke_rsp=32'h63636363 4 times, sb never granted.
  - With SBOX_ARB_ROUND_ROBIN_EN: grant order ke, sb, ke, sb with matching responses (sb_rsp=32'h7c7c7c7c).
- ke_req held while sbox_in_vld pulses for one cycle with a table of all 8'hAA -> no grant in the load cycle; grant the following cycle, then ke_rsp=32'haaaaaaaa.
- Grant in cycle N, reset asserted in cycle N+1 -> ke_rsp_vld=0, busy=0, sbox_available=0 in N+1 and after; requests ignored until reload.
